// File: rtl/nts_tx_arbiter_pkg.sv
// Shared types and widths for the NTS TX arbiter: FSM state encoding and
// statistics counter widths.
package nts_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int FWD_CNT_WIDTH   = 32;
    localparam int ABORT_CNT_WIDTH = 16;
    localparam int BYTES_WIDTH     = 4;

    // Saturating increment for the abort counter.
    function automatic logic [ABORT_CNT_WIDTH-1:0] sat_inc_abort(
        input logic [ABORT_CNT_WIDTH-1:0] value
    );
        return (value == '1) ? value : value + ABORT_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/nts_rr_pick.sv
// Combinational round-robin search: first set request bit at or above ptr,
// wrapping modulo N.
module nts_rr_pick #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 4
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 valid
);

    logic [2*N-1:0] rotated;
    int             sum;

    // Rotating the doubled vector puts the pointer's bit at position 0.
    assign rotated = {req, req} >> ptr;

    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = 0;
        for (int j = 0; j < N; j++) begin
            if (!valid && rotated[j]) begin
                sum   = int'(ptr) + j;
                if (sum >= N) begin
                    sum = sum - N;
                end
                valid = 1'b1;
                idx   = IDX_WIDTH'(sum);
            end
        end
    end

endmodule

// File: rtl/nts_tx_arbiter.sv
// Round-robin arbiter multiplexing per-engine TX FIFOs onto one extractor
// FIFO interface, one packet per grant.
module nts_tx_arbiter
    import nts_tx_arbiter_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int MAC_DATA_WIDTH = 64,
    parameter int IDX_WIDTH      = 4
) (
    input  logic                              i_clk,
    input  logic                              i_areset_n,

    input  logic [ENGINES-1:0]                i_engine_packet_available,
    output logic [ENGINES-1:0]                o_engine_packet_read,
    input  logic [ENGINES-1:0]                i_engine_fifo_empty,
    output logic [ENGINES-1:0]                o_engine_fifo_rd_en,
    input  logic [ENGINES*MAC_DATA_WIDTH-1:0] i_engine_fifo_rd_data,
    input  logic [ENGINES*BYTES_WIDTH-1:0]    i_engine_bytes_last_word,

    output logic                              o_packet_available,
    input  logic                              i_packet_read,
    output logic                              o_fifo_empty,
    input  logic                              i_fifo_rd_en,
    output logic [MAC_DATA_WIDTH-1:0]         o_fifo_rd_data,
    output logic [BYTES_WIDTH-1:0]            o_bytes_last_word,

    output logic                              o_grant_valid,
    output logic [IDX_WIDTH-1:0]              o_grant_index,
    output logic [FWD_CNT_WIDTH-1:0]          o_packets_forwarded,
    output logic [ABORT_CNT_WIDTH-1:0]        o_grant_aborts
);

    arb_state_t                 state;
    arb_state_t                 state_n;
    logic [IDX_WIDTH-1:0]       rr_ptr;
    logic [IDX_WIDTH-1:0]       grant_idx;
    logic [IDX_WIDTH-1:0]       next_ptr;
    logic [IDX_WIDTH-1:0]       pick_idx;
    logic                       pick_valid;
    logic                       granted;
    logic                       complete;
    logic                       abort;
    logic [FWD_CNT_WIDTH-1:0]   fwd_cnt;
    logic [ABORT_CNT_WIDTH-1:0] abort_cnt;

    nts_rr_pick #(
        .N         (ENGINES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_pick (
        .req   (i_engine_packet_available),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign granted  = (state == ST_GRANTED);
    // Completion wins over a simultaneous availability drop.
    assign complete = granted & i_packet_read;
    assign abort    = granted & ~i_packet_read & ~o_packet_available;
    assign next_ptr = (grant_idx == IDX_WIDTH'(ENGINES - 1)) ? '0
                                                             : grant_idx + IDX_WIDTH'(1);

    // Extractor-side mux and engine-side strobe decode; idle values outside GRANTED.
    always_comb begin
        o_packet_available   = 1'b0;
        o_fifo_empty         = 1'b1;
        o_fifo_rd_data       = '0;
        o_bytes_last_word    = '0;
        o_engine_fifo_rd_en  = '0;
        o_engine_packet_read = '0;
        if (granted) begin
            for (int e = 0; e < ENGINES; e++) begin
                if (grant_idx == IDX_WIDTH'(e)) begin
                    o_packet_available      = i_engine_packet_available[e];
                    o_fifo_empty            = i_engine_fifo_empty[e];
                    o_fifo_rd_data          = i_engine_fifo_rd_data[e*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
                    o_bytes_last_word       = i_engine_bytes_last_word[e*BYTES_WIDTH +: BYTES_WIDTH];
                    o_engine_fifo_rd_en[e]  = i_fifo_rd_en;
                    o_engine_packet_read[e] = i_packet_read;
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_n = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (complete) begin
                    state_n = ST_RELEASE;
                end else if (abort) begin
                    state_n = ST_IDLE;
                end
            end
            ST_RELEASE: state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            fwd_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && pick_valid) begin
                grant_idx <= pick_idx;
            end
            if (complete || abort) begin
                rr_ptr <= next_ptr;
            end
            if (complete) begin
                fwd_cnt <= fwd_cnt + FWD_CNT_WIDTH'(1);
            end
            if (abort) begin
                abort_cnt <= sat_inc_abort(abort_cnt);
            end
        end
    end

    assign o_grant_valid       = granted;
    assign o_grant_index       = granted ? grant_idx : '0;
    assign o_packets_forwarded = fwd_cnt;
    assign o_grant_aborts      = abort_cnt;

endmodule

// File: tb/tb_nts_tx_arbiter.sv
// Self-checking bench: randomized and directed stimulus against a behavioural
// grant model (4 engines), plus a single-engine pass-through instance.
module tb_nts_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4-engine DUT signals
    logic [N-1:0]   avail, empty, e_rd_en, e_pkt_read;
    logic [N*W-1:0] rd_data_bus;
    logic [N*4-1:0] bytes_bus;
    logic           pkt_read, fifo_rd_en;
    logic           pkt_avail_o, fifo_empty_o, gv_o;
    logic [W-1:0]   rd_data_o;
    logic [3:0]     blw_o;
    logic [IW-1:0]  gi_o;
    logic [31:0]    fwd_o;
    logic [15:0]    abt_o;

    // 1-engine DUT signals
    logic [0:0]   avail1, empty1, e_rd_en1, e_pkt_read1;
    logic [W-1:0] rdd1, rd_data1_o;
    logic [3:0]   blw1, blw1_o;
    logic         pr1, rden1, pa1_o, fe1_o, gv1_o;
    logic [0:0]   gi1_o;
    logic [31:0]  fwd1_o;
    logic [15:0]  abt1_o;

    nts_tx_arbiter #(.ENGINES(N), .MAC_DATA_WIDTH(W), .IDX_WIDTH(IW)) u_dut (
        .i_clk                     (clk),
        .i_areset_n                (rst_n),
        .i_engine_packet_available (avail),
        .o_engine_packet_read      (e_pkt_read),
        .i_engine_fifo_empty       (empty),
        .o_engine_fifo_rd_en       (e_rd_en),
        .i_engine_fifo_rd_data     (rd_data_bus),
        .i_engine_bytes_last_word  (bytes_bus),
        .o_packet_available        (pkt_avail_o),
        .i_packet_read             (pkt_read),
        .o_fifo_empty              (fifo_empty_o),
        .i_fifo_rd_en              (fifo_rd_en),
        .o_fifo_rd_data            (rd_data_o),
        .o_bytes_last_word         (blw_o),
        .o_grant_valid             (gv_o),
        .o_grant_index             (gi_o),
        .o_packets_forwarded       (fwd_o),
        .o_grant_aborts            (abt_o)
    );

    nts_tx_arbiter #(.ENGINES(1), .MAC_DATA_WIDTH(W), .IDX_WIDTH(1)) u_dut1 (
        .i_clk                     (clk),
        .i_areset_n                (rst_n),
        .i_engine_packet_available (avail1),
        .o_engine_packet_read      (e_pkt_read1),
        .i_engine_fifo_empty       (empty1),
        .o_engine_fifo_rd_en       (e_rd_en1),
        .i_engine_fifo_rd_data     (rdd1),
        .i_engine_bytes_last_word  (blw1),
        .o_packet_available        (pa1_o),
        .i_packet_read             (pr1),
        .o_fifo_empty              (fe1_o),
        .i_fifo_rd_en              (rden1),
        .o_fifo_rd_data            (rd_data1_o),
        .o_bytes_last_word         (blw1_o),
        .o_grant_valid             (gv1_o),
        .o_grant_index             (gi1_o),
        .o_packets_forwarded       (fwd1_o),
        .o_grant_aborts            (abt1_o)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: phase 0 = no grant, 1 = granted, 2 = release gap.
    logic [W-1:0]  eng_data  [N];
    logic [3:0]    eng_bytes [N];
    int            m_phase, m_idx, m_ptr;
    int unsigned   m_fwd;
    int            m_abt;

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_ptr = 0; m_fwd = 0; m_abt = 0;
    endtask

    // Nearest requester at or after the pointer, measured as circular distance.
    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ((i - ptr + N) % N) < bestd) begin
                bestd = (i - ptr + N) % N;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_step();
        int p;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                p = model_pick(avail, m_ptr);
                if (p >= 0) begin
                    m_idx   = p;
                    m_phase = 1;
                end
            end
            1: begin
                if (pkt_read) begin
                    m_fwd++;
                    m_ptr   = (m_idx + 1) % N;
                    m_phase = 2;
                end else if (!avail[m_idx]) begin
                    if (m_abt < 16'hFFFF) m_abt++;
                    m_ptr   = (m_idx + 1) % N;
                    m_phase = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        bit g = (m_phase == 1);
        check("grant_valid",     64'(gv_o),         64'(g));
        check("grant_index",     64'(gi_o),         g ? 64'(m_idx) : 64'd0);
        check("packet_avail",    64'(pkt_avail_o),  g ? 64'(avail[m_idx]) : 64'd0);
        check("fifo_empty",      64'(fifo_empty_o), g ? 64'(empty[m_idx]) : 64'd1);
        check("fifo_rd_data",    rd_data_o,         g ? eng_data[m_idx] : 64'd0);
        check("bytes_last_word", 64'(blw_o),        g ? 64'(eng_bytes[m_idx]) : 64'd0);
        check("eng_fifo_rd_en",  64'(e_rd_en),      (g && fifo_rd_en) ? (64'd1 << m_idx) : 64'd0);
        check("eng_packet_read", 64'(e_pkt_read),   (g && pkt_read)   ? (64'd1 << m_idx) : 64'd0);
        check("packets_fwd",     64'(fwd_o),        64'(m_fwd));
        check("grant_aborts",    64'(abt_o),        64'(m_abt));
    endtask

    // Called at a falling edge: sets inputs with fresh engine data, then settles.
    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] e, input logic r, input logic p);
        avail = a; empty = e; fifo_rd_en = r; pkt_read = p;
        for (int i = 0; i < N; i++) begin
            eng_data[i]  = {$urandom, $urandom};
            eng_bytes[i] = 4'($urandom);
            rd_data_bus[i*W +: W] = eng_data[i];
            bytes_bus[i*4 +: 4]   = eng_bytes[i];
        end
        #1;
    endtask

    task automatic tick();
        compare_all();
        model_step();
        @(negedge clk);
    endtask

    logic [N-1:0] r_avail;
    int           nw;
    logic [W-1:0] w1;
    logic [3:0]   b1;

    initial begin
        rst_n = 1'b0;
        avail1 = '0; empty1 = '1; rdd1 = '0; blw1 = '0; pr1 = 1'b0; rden1 = 1'b0;
        model_reset();
        drive('0, '1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_grant_valid", 64'(gv_o), 64'd0);
        check("reset_fwd",         64'(fwd_o), 64'd0);
        rst_n = 1'b1;

        // Only engine 2 available: grant 2, six reads, then packet consumed.
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("a_idle_first", 64'(gv_o), 64'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            drive(4'b0100, 4'b0000, 1'b1, 1'b0);
            check("a_grant_index", 64'(gi_o), 64'd2);
            check("a_rd_en_only2", 64'(e_rd_en), 64'b0100);
            tick();
        end
        drive(4'b0100, 4'b0000, 1'b0, 1'b1);
        check("a_packet_read2", 64'(e_pkt_read), 64'b0100);
        tick();
        check("a_forwarded1", 64'(fwd_o), 64'd1);
        check("a_release",    64'(gv_o), 64'd0);
        drive('0, '1, 1'b0, 1'b0);
        tick();

        // Engine 3 granted, reset lands mid-transfer.
        drive(4'b1000, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b1000, 4'b0000, 1'b1, 1'b0);
        check("d_grant3", 64'(gi_o), 64'd3);
        tick();
        drive(4'b1000, 4'b0000, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("d_rst_gv",       64'(gv_o), 64'd0);
        check("d_rst_rd_en",    64'(e_rd_en), 64'd0);
        check("d_rst_pkt_read", 64'(e_pkt_read), 64'd0);
        check("d_rst_empty",    64'(fifo_empty_o), 64'd1);
        check("d_rst_fwd",      64'(fwd_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // All engines available: strict rotation starting from engine 0.
        for (int p = 0; p < 8; p++) begin
            drive(4'b1111, 4'b0000, 1'b0, 1'b0);
            tick();
            drive(4'b1111, 4'b0000, 1'b0, 1'b1);
            check("b_order", 64'(gi_o), 64'(p % 4));
            tick();
            drive(4'b1111, 4'b0000, 1'b0, 1'b0);
            check("b_release_gap", 64'(gv_o), 64'd0);
            tick();
        end
        check("b_forwarded8", 64'(fwd_o), 64'd8);

        // Engine 1 granted, withdraws before read; engine 2 is next.
        drive(4'b0010, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        check("c_grant1", 64'(gi_o), 64'd1);
        tick();
        check("c_aborts1", 64'(abt_o), 64'd1);
        check("c_idle",    64'(gv_o), 64'd0);
        drive(4'b0100, 4'b0000, 1'b0, 1'b0);
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 1'b1);
        check("c_grant2", 64'(gi_o), 64'd2);
        tick();
        drive('0, '1, 1'b0, 1'b0);
        tick();

        // Randomized traffic with sticky, occasionally toggling availability.
        r_avail = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) r_avail[i] = ~r_avail[i];
            end
            drive(r_avail, N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            tick();
        end
        drive('0, '1, 1'b0, 1'b0);
        tick();
        tick();

        // Single engine: back-to-back packets pass straight through.
        avail1 = 1'b1; empty1 = 1'b0;
        #1;
        tick();
        for (int p = 0; p < 3; p++) begin
            nw = 2 + p;
            for (int w = 0; w < nw; w++) begin
                w1 = {$urandom, $urandom};
                b1 = 4'($urandom);
                rdd1 = w1; blw1 = b1; rden1 = 1'b1; pr1 = (w == nw - 1);
                #1;
                check("e_grant_valid", 64'(gv1_o), 64'd1);
                check("e_rd_data",     rd_data1_o, w1);
                check("e_bytes",       64'(blw1_o), 64'(b1));
                check("e_rd_en",       64'(e_rd_en1), 64'd1);
                check("e_pkt_read",    64'(e_pkt_read1), (w == nw - 1) ? 64'd1 : 64'd0);
                tick();
            end
            rden1 = 1'b0; pr1 = 1'b0;
            #1;
            check("e_release", 64'(gv1_o), 64'd0);
            tick();
            check("e_idle", 64'(gv1_o), 64'd0);
            tick();
        end
        check("e_forwarded3", 64'(fwd1_o), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nts_tx_arbiter.md
NTS_TX_ARBITER -- requirements
Module: nts_tx_arbiter

Interface
REQ-001 Parameter ENGINES, default 4, number of engine TX ports; legal range 1..16.
REQ-002 Parameter MAC_DATA_WIDTH, default 64, TX FIFO word width.
REQ-003 Parameter IDX_WIDTH, default 4, width of engine index; SHALL satisfy 2^IDX_WIDTH >= ENGINES.
REQ-004 One clock; reset is asynchronous and active-low: i_clk, i_areset_n.
REQ-005 i_clk  in  1  sole clock; all state on rising edge.
REQ-006 i_areset_n  in  1  async active-low reset.
REQ-007 i_engine_packet_available  in  ENGINES  per-engine "TX packet ready".
REQ-008 o_engine_packet_read  out  ENGINES  per-engine one-cycle packet-consumed pulse.
REQ-009 i_engine_fifo_empty  in  ENGINES  per-engine TX FIFO empty.
REQ-010 o_engine_fifo_rd_en  out  ENGINES  per-engine TX FIFO read enable.
REQ-011 i_engine_fifo_rd_data  in  ENGINES*MAC_DATA_WIDTH  engine e at [e*MAC_DATA_WIDTH +: MAC_DATA_WIDTH].
REQ-012 i_engine_bytes_last_word  in  ENGINES*4  engine e at [e*4 +: 4].
REQ-013 o_packet_available  out  1  to extractor: granted packet ready.
REQ-014 i_packet_read  in  1  from extractor: packet consumed pulse.
REQ-015 o_fifo_empty  out  1;  i_fifo_rd_en  in  1;  o_fifo_rd_data  out  MAC_DATA_WIDTH;  o_bytes_last_word  out  4 -- extractor FIFO interface.
REQ-016 o_grant_valid  out  1;  o_grant_index  out  IDX_WIDTH -- current grant status.
REQ-017 o_packets_forwarded  out  32  count of completed packets;  o_grant_aborts  out  16  count of aborted grants.

Function
REQ-018 FSM states IDLE, GRANTED, RELEASE; reset state IDLE.
REQ-019 IDLE: if any i_engine_packet_available bit set, SHALL select next set bit searching from rr_ptr upward with wrap, latch it as grant_idx, enter GRANTED next cycle (1-cycle grant latency).
REQ-020 GRANTED: o_packet_available, o_fifo_empty, o_fifo_rd_data, o_bytes_last_word SHALL combinationally mirror engine grant_idx; i_fifo_rd_en SHALL drive only o_engine_fifo_rd_en[grant_idx], zero latency.
REQ-021 GRANTED with i_packet_read=1: o_engine_packet_read[grant_idx] pulses same cycle, o_packets_forwarded increments (wraps at 2^32), rr_ptr <= (grant_idx+1) mod ENGINES, enter RELEASE.
REQ-022 RELEASE: one cycle, all extractor-side outputs idle, then IDLE; gives engine one cycle to deassert packet_available.
REQ-023 GRANTED with i_engine_packet_available[grant_idx]=0 and no i_packet_read: abort, o_grant_aborts increments (saturates at 0xFFFF), rr_ptr advances as REQ-021, enter IDLE.
REQ-024 Simultaneous i_packet_read and packet_available drop: treated as completion (REQ-021), not abort.
REQ-025 Outside GRANTED: o_packet_available=0, o_fifo_empty=1, o_fifo_rd_data=0, o_bytes_last_word=0, o_engine_fifo_rd_en=0, o_engine_packet_read=0; i_packet_read and i_fifo_rd_en ignored.
REQ-026 i_fifo_rd_en while o_fifo_empty=1 in GRANTED SHALL be forwarded unchanged; engine FIFO owns underflow protection.
REQ-027 At most one bit of o_engine_fifo_rd_en and o_engine_packet_read set in any cycle.
REQ-028 ENGINES=1: arbiter degenerates to pass-through with REQ-019 latency and REQ-022 gap.
REQ-029 o_grant_valid=1 exactly in GRANTED; o_grant_index=grant_idx, 0 outside GRANTED.

Reset
REQ-030 i_areset_n low SHALL immediately force IDLE, rr_ptr=0, grant_idx=0, both counters 0, all outputs to REQ-025 values, including mid-packet; no engine packet_read is issued for an interrupted transfer.

Structure
REQ-031 FSM state encodings and counter widths SHALL live in shared package nts_tx_arbiter_pkg.
REQ-032 Round-robin search SHALL be one sub-module nts_rr_pick (request vector, pointer -> index, valid), purely combinational.
REQ-033 Target 150-300 lines RTL; no memories; data mux is combinational, no added pipeline stage.

Verification
REQ-034 ENGINES=4, only engine 2 available, extractor reads 6 words then i_packet_read -> grant_index=2 one cycle later, 6 rd_en pulses only on engine 2, packet_read[2] pulse, forwarded=1.
REQ-035 All 4 engines permanently available, 8 packets consumed -> grant order 0,1,2,3,0,1,2,3, each separated by one RELEASE cycle.
REQ-036 Engine 1 granted, drops packet_available before read -> return to IDLE, aborts=1, next grant engine 2 if available.
REQ-037 Reset asserted mid-transfer on engine 3 -> all outputs idle immediately, counters 0, after release first grant searched from engine 0.
REQ-038 ENGINES=1, back-to-back packets -> pass-through data matches, bytes_last_word matches per packet, one idle cycle plus one grant cycle between packets.
